// File: rtl/led_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : led_seq_ctrl                                              |
// | Purpose  : Command-driven LED bar sequencer. Accepts mode/divider/   |
// |            repetition commands over valid/ready, runs a prescaler   |
// |            and steps the LED pattern on every tick.                 |
// | Options  : LED_SEQ_PWM_EN adds a cmd_duty port and 4-bit PWM         |
// |            dimming of the LED outputs.                              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module led_seq_ctrl #(
  parameter int LED_W = 8,
  parameter int DIV_W = 27,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic [REP_W-1:0] cmd_reps,
`ifdef LED_SEQ_PWM_EN
  input  logic [3:0]       cmd_duty,
`endif
  output logic [LED_W-1:0] led,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [2:0] MODE_ROTL   = 3'd1;
  localparam logic [2:0] MODE_ROTR   = 3'd2;
  localparam logic [2:0] MODE_BOUNCE = 3'd3;
  localparam logic [2:0] MODE_BLINK  = 3'd4;

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
  localparam logic [LED_W-1:0] PAT_ONE = LED_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [2:0]       mode;
  logic [DIV_W-1:0] div;
  logic [REP_W-1:0] reps;
  logic [LED_W-1:0] pattern;
  logic [DIV_W-1:0] presc;
  logic [REP_W-1:0] step_cnt;
  logic             dir;        // 0 = moving left (towards MSB), 1 = right

  logic             accept;
  logic [DIV_W-1:0] presc_last;
  logic             step_now;
  logic [REP_W-1:0] cnt_inc;
  logic             final_step;
  logic [LED_W-1:0] init_pat;
  logic [LED_W-1:0] next_pat;
  logic             next_dir;

  assign accept     = cmd_valid & cmd_ready;
  // A divider of 0 behaves like 1, so the terminal prescaler value is 0.
  assign presc_last = (div == '0) ? '0 : div - DIV_ONE;
  assign step_now   = (state == ST_RUN) && (presc == presc_last);
  assign cnt_inc    = step_cnt + REP_ONE;
  assign final_step = step_now && (reps != '0) && (cnt_inc == reps);

  // Initial pattern loaded in LOAD for the latched mode.
  always_comb begin
    init_pat = '0;
    case (mode)
      MODE_ROTL, MODE_ROTR, MODE_BOUNCE: init_pat = PAT_ONE;
      MODE_BLINK:                        init_pat = '1;
      default:                           init_pat = '0;
    endcase
  end

  // Pattern and bounce direction after one step.
  always_comb begin
    next_pat = pattern;
    next_dir = dir;
    case (mode)
      MODE_ROTL:  next_pat = {pattern[LED_W-2:0], pattern[LED_W-1]};
      MODE_ROTR:  next_pat = {pattern[0], pattern[LED_W-1:1]};
      MODE_BLINK: next_pat = ~pattern;
      MODE_BOUNCE: begin
        if (!dir) begin
          next_pat = pattern << 1;
          if (next_pat[LED_W-1]) next_dir = 1'b1;
        end else begin
          next_pat = pattern >> 1;
          if (next_pat[0]) next_dir = 1'b0;
        end
      end
      default:    next_pat = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a new command always wins over run completion.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_RUN;
      ST_RUN: begin
        if (accept)          state_nxt = ST_LOAD;
        else if (final_step) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded handshake and status outputs.
  always_comb begin
    cmd_ready = (state != ST_LOAD);
    busy      = (state == ST_LOAD) || (state == ST_RUN);
  end

  // Command latch, prescaler, step counter, pattern and pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode     <= '0;
      div      <= '0;
      reps     <= '0;
      pattern  <= '0;
      presc    <= '0;
      step_cnt <= '0;
      dir      <= 1'b0;
      tick     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (accept) begin
        mode <= cmd_mode;
        div  <= cmd_div;
        reps <= cmd_reps;
      end
      tick <= step_now;
      done <= final_step & ~accept;
      case (state)
        ST_LOAD: begin
          pattern  <= init_pat;
          presc    <= '0;
          step_cnt <= '0;
          dir      <= 1'b0;
        end
        ST_RUN: begin
          if (step_now) begin
            presc    <= '0;
            pattern  <= next_pat;
            dir      <= next_dir;
            step_cnt <= cnt_inc;
          end else begin
            presc <= presc + DIV_ONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LED_SEQ_PWM_EN
  logic [3:0] duty;
  logic [3:0] pwm_cnt;

  // Duty latch and free-running PWM counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty    <= 4'd15;
      pwm_cnt <= 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      if (accept) duty <= cmd_duty;
    end
  end

  assign led = pattern & {LED_W{pwm_cnt <= duty}};
`else
  assign led = pattern;
`endif

endmodule
`default_nettype wire
